exec_unit: RTL and testbench

EXEC_UNIT -- requirements
Module: exec_unit

---
 rtl/exec_pkg.sv | 50 +++++
 rtl/muldiv_iter.sv | 90 +++++++++
 rtl/exec_unit.sv | 207 ++++++++++++++++++++
 tb/tb_exec_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: operation codes, sequencer states and the multiply/divide sign-fix helper.
// Optional multiply/divide datapath is compiled in with macro EXEC_MULDIV_EN.
package exec_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_AND   = 5'b00000;
  localparam logic [OP_W-1:0] OP_OR    = 5'b00001;
  localparam logic [OP_W-1:0] OP_ADD   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADDU  = 5'b00011;
  localparam logic [OP_W-1:0] OP_XOR   = 5'b00100;
  localparam logic [OP_W-1:0] OP_SUBU  = 5'b00101;
  localparam logic [OP_W-1:0] OP_SUB   = 5'b00110;
  localparam logic [OP_W-1:0] OP_PASSB = 5'b00111;
  localparam logic [OP_W-1:0] OP_SLT   = 5'b01000;
  localparam logic [OP_W-1:0] OP_SLTU  = 5'b01001;
  localparam logic [OP_W-1:0] OP_NOR   = 5'b01100;
  localparam logic [OP_W-1:0] OP_SLL   = 5'b01101;
  localparam logic [OP_W-1:0] OP_SRL   = 5'b01110;
  localparam logic [OP_W-1:0] OP_SRA   = 5'b01111;
  localparam logic [OP_W-1:0] OP_MULT  = 5'b10000;
  localparam logic [OP_W-1:0] OP_MULTU = 5'b10001;
  localparam logic [OP_W-1:0] OP_DIV   = 5'b10010;
  localparam logic [OP_W-1:0] OP_DIVU  = 5'b10011;
  localparam logic [OP_W-1:0] OP_MFHI  = 5'b10100;
  localparam logic [OP_W-1:0] OP_MFLO  = 5'b10101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_e;

  // neg_lo: negate product (whole HI:LO) or quotient; neg_hi: negate remainder
  typedef struct packed {
    logic neg_lo;
    logic neg_hi;
  } sign_fix_t;

  // Signs to re-apply after the magnitude-only iteration
  function automatic sign_fix_t fix_signs(input logic is_signed, input logic is_div,
                                          input logic sign_a, input logic sign_b);
    sign_fix_t f;
    f.neg_lo = is_signed && (sign_a ^ sign_b);
    f.neg_hi = is_signed && (is_div ? sign_a : (sign_a ^ sign_b));
    return f;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: unsigned shift-add multiplier / restoring divider, one bit per cycle,
// WIDTH iterations after start. op=0 multiplies, op=1 divides.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic             op_q, op_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  assign sum    = {1'b0, hi_q} + {1'b0, b_q};
  assign rem_sh = {hi_q, lo_q[WIDTH-1]};
  assign ge     = (rem_sh >= {1'b0, b_q});
  assign diff   = rem_sh[WIDTH-1:0] - b_q;

  // Load on start, then one multiply or divide step per cycle
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    done_d = 1'b0;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    b_d    = b_q;
    if (start) begin
      busy_d = 1'b1;
      op_d   = op;
      cnt_d  = '0;
      hi_d   = '0;
      lo_d   = a;
      b_d    = b;
    end else if (busy_q) begin
      if (!op_q) begin
        if (lo_q[0]) {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        else         {hi_d, lo_d} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
      end else begin
        hi_d = ge ? diff : rem_sh[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], ge};
      end
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(WIDTH - 1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      op_q   <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      op_q   <= op_d;
      done_q <= done_d;
      cnt_q  <= cnt_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      b_q    <= b_d;
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: rtl/exec_unit.sv
// exec_unit: valid/ready execution unit with single-cycle ALU ops and, with macro
// EXEC_MULDIV_EN, an iterative multiply/divide writing HI/LO.
module exec_unit
  import exec_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OP_W-1:0]    aluctrl,
  input  logic [WIDTH-1:0]   d1_in,
  input  logic [WIDTH-1:0]   d2_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   d1_out,
  output logic               zero,
  output logic               ovf,
  output logic               ill
);
  localparam int unsigned MSB = WIDTH - 1;

  logic             accept, idle;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf, alu_ill, alu_md;
  logic             out_valid_q, out_valid_d, zero_q, zero_d, ovf_q, ovf_d, ill_q, ill_d;
  logic [WIDTH-1:0] d1_out_q, d1_out_d;

`ifdef EXEC_MULDIV_EN
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, a_orig_q, a_orig_d;
  sign_fix_t          fix_q, fix_d;
  logic               div_q, div_d, bzero_q, bzero_d;
  logic               md_start, md_op, md_signed, md_done;
  logic [WIDTH-1:0]   md_a, md_b, md_hi, md_lo;
  logic [2*WIDTH-1:0] prod_neg;

  assign idle = (state_q == IDLE);
`else
  assign idle = 1'b1;
`endif

  assign in_ready = idle && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign sum      = d1_in + d2_in;
  assign diff     = d1_in - d2_in;

  // Single-cycle result and classification of the offered operation
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    alu_md  = 1'b0;
    case (aluctrl)
      OP_AND:   alu_res = d1_in & d2_in;
      OP_OR:    alu_res = d1_in | d2_in;
      OP_XOR:   alu_res = d1_in ^ d2_in;
      OP_NOR:   alu_res = ~(d1_in | d2_in);
      OP_PASSB: alu_res = d2_in;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (d1_in[MSB] == d2_in[MSB]) && (sum[MSB] != d1_in[MSB]);
      end
      OP_ADDU:  alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (d1_in[MSB] != d2_in[MSB]) && (diff[MSB] != d1_in[MSB]);
      end
      OP_SUBU:  alu_res = diff;
      OP_SLT:   alu_res = WIDTH'($signed(d1_in) < $signed(d2_in));
      OP_SLTU:  alu_res = WIDTH'(d1_in < d2_in);
      OP_SLL:   alu_res = d2_in << shamt;
      OP_SRL:   alu_res = d2_in >> shamt;
      OP_SRA:   alu_res = WIDTH'($signed(d2_in) >>> shamt);
`ifdef EXEC_MULDIV_EN
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_md = 1'b1;
      OP_MFHI:  alu_res = hi_q;
      OP_MFLO:  alu_res = lo_q;
`endif
      default:  alu_ill = 1'b1;
    endcase
  end

  // Output register: load on single-cycle acceptance, drop valid on consumer transfer
  always_comb begin
    out_valid_d = out_valid_q;
    d1_out_d    = d1_out_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    ill_d       = ill_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept && !alu_md) begin
      out_valid_d = 1'b1;
      d1_out_d    = alu_res;
      zero_d      = (alu_res == '0);
      ovf_d       = alu_ovf;
      ill_d       = alu_ill;
    end
  end

  // Output beat registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      d1_out_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      ill_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      d1_out_q    <= d1_out_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      ill_q       <= ill_d;
    end
  end

  assign out_valid = out_valid_q;
  assign d1_out    = d1_out_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign ill       = ill_q;

`ifdef EXEC_MULDIV_EN
  assign md_signed = (aluctrl == OP_MULT) || (aluctrl == OP_DIV);
  assign md_op     = aluctrl[1];
  assign md_start  = accept && alu_md;
  assign md_a      = (md_signed && d1_in[MSB]) ? -d1_in : d1_in;
  assign md_b      = (md_signed && d2_in[MSB]) ? -d2_in : d2_in;
  assign prod_neg  = -{md_hi, md_lo};

  muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start),
    .op    (md_op),
    .a     (md_a),
    .b     (md_b),
    .done  (md_done),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  // Sequencer: launch, wait for the iterations, then sign-correct into HI/LO
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    a_orig_d = a_orig_q;
    fix_d    = fix_q;
    div_d    = div_q;
    bzero_d  = bzero_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          state_d  = md_op ? DIV : MUL;
          a_orig_d = d1_in;
          div_d    = md_op;
          bzero_d  = (d2_in == '0);
          fix_d    = fix_signs(md_signed, md_op, d1_in[MSB], d2_in[MSB]);
        end
      end
      MUL, DIV: begin
        if (md_done) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (div_q && bzero_q) begin
          lo_d = '1;
          hi_d = a_orig_q;
        end else if (div_q) begin
          lo_d = fix_q.neg_lo ? -md_lo : md_lo;
          hi_d = fix_q.neg_hi ? -md_hi : md_hi;
        end else begin
          {hi_d, lo_d} = fix_q.neg_lo ? prod_neg : {md_hi, md_lo};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer and HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      a_orig_q <= '0;
      fix_q    <= '0;
      div_q    <= 1'b0;
      bzero_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_orig_q <= a_orig_d;
      fix_q    <= fix_d;
      div_q    <= div_d;
      bzero_q  <= bzero_d;
    end
  end
`endif

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed scoreboard bench for exec_unit (WIDTH=32).
module tb_exec_unit;
  localparam logic [4:0] C_AND = 5'b00000, C_OR = 5'b00001, C_ADD = 5'b00010, C_ADDU = 5'b00011;
  localparam logic [4:0] C_XOR = 5'b00100, C_SUBU = 5'b00101, C_SUB = 5'b00110, C_PASS = 5'b00111;
  localparam logic [4:0] C_SLT = 5'b01000, C_SLTU = 5'b01001, C_NOR = 5'b01100, C_SLL = 5'b01101;
  localparam logic [4:0] C_SRL = 5'b01110, C_SRA = 5'b01111, C_MULT = 5'b10000, C_MULTU = 5'b10001;
  localparam logic [4:0] C_DIV = 5'b10010, C_DIVU = 5'b10011, C_MFHI = 5'b10100, C_MFLO = 5'b10101;

  typedef struct {
    logic [31:0] d;
    logic        ovf;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic        in_ready, out_valid, zero, ovf, ill;
  logic [4:0]  aluctrl = '0, shamt = '0;
  logic [31:0] d1_in = '0, d2_in = '0, d1_out;

  exp_t        q[$];
  logic [31:0] m_hi = '0, m_lo = '0;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  exec_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .aluctrl(aluctrl), .d1_in(d1_in), .d2_in(d2_in), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .d1_out(d1_out),
    .zero(zero), .ovf(ovf), .ill(ill)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: push the expected beat, or update the model HI/LO
  task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    exp_t   e;
    logic   beat;
    longint r;
    e.d = '0; e.ovf = 1'b0; e.ill = 1'b0; beat = 1'b1;
    case (op)
      C_AND:  e.d = a & b;
      C_OR:   e.d = a | b;
      C_XOR:  e.d = a ^ b;
      C_NOR:  e.d = ~(a | b);
      C_PASS: e.d = b;
      C_ADD: begin
        e.d = a + b;
        r = longint'($signed(a)) + longint'($signed(b));
        e.ovf = (r != longint'($signed(e.d)));
      end
      C_ADDU: e.d = a + b;
      C_SUB: begin
        e.d = a - b;
        r = longint'($signed(a)) - longint'($signed(b));
        e.ovf = (r != longint'($signed(e.d)));
      end
      C_SUBU: e.d = a - b;
      C_SLT:  e.d = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      C_SLTU: e.d = (a < b) ? 32'd1 : 32'd0;
      C_SLL:  e.d = b << sh;
      C_SRL:  e.d = b >> sh;
      C_SRA:  e.d = $signed(b) >>> sh;
`ifdef EXEC_MULDIV_EN
      C_MULT: begin
        {m_hi, m_lo} = 64'(longint'($signed(a)) * longint'($signed(b)));
        beat = 1'b0;
      end
      C_MULTU: begin
        {m_hi, m_lo} = {32'b0, a} * {32'b0, b};
        beat = 1'b0;
      end
      C_DIV: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = 32'($signed(a) / $signed(b)); m_hi = 32'($signed(a) % $signed(b)); end
        beat = 1'b0;
      end
      C_DIVU: begin
        if (b == 0) begin m_lo = '1; m_hi = a; end
        else begin m_lo = a / b; m_hi = a % b; end
        beat = 1'b0;
      end
      C_MFHI: e.d = m_hi;
      C_MFLO: e.d = m_lo;
`endif
      default: e.ill = 1'b1;
    endcase
    if (beat) q.push_back(e);
  endtask

  // Offer one operation (called just after a rising edge); returns cycles waited for in_ready
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, output int waited);
    in_valid = 1'b1; aluctrl = op; d1_in = a; d2_in = b; shamt = sh;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 60) chk("accept_timeout", 64'(in_ready), 64'd1);
    else model(op, a, b, sh);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Scoreboard: compare every output transfer against the oldest expected beat
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("d1_out", 64'(d1_out), 64'(e.d));
        chk("ovf", 64'(ovf), 64'(e.ovf));
        chk("ill", 64'(ill), 64'(e.ill));
        chk("zero", 64'(zero), 64'(e.d == 0));
      end
    end
  end

  logic [4:0] ops [16] = '{C_AND, C_OR, C_XOR, C_NOR, C_PASS, C_ADD, C_ADDU, C_SUB,
                           C_SUBU, C_SLT, C_SLTU, C_SLL, C_SRL, C_SRA, 5'b01010, 5'b11111};

  initial begin
    int w;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_d1_out", 64'(d1_out), 64'd0);
    chk("rst_flags", {61'b0, zero, ovf, ill}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Signed overflow, one-cycle latency
    send(C_ADD, 32'h7FFF_FFFF, 32'h1, 5'd0, w);
    @(negedge clk);
    chk("add_latency", 64'(out_valid), 64'd1);
    chk("add_result", 64'(d1_out), 64'h8000_0000);
    chk("add_ovf", 64'(ovf), 64'd1);
    @(posedge clk); #1;
    send(C_ADDU, 32'h7FFF_FFFF, 32'h1, 5'd0, w);
    send(C_SUB, 32'h8000_0000, 32'h1, 5'd0, w);
    send(C_SUB, 32'h1234_5678, 32'h1234_5678, 5'd0, w);
    send(C_SRA, 32'd0, 32'hF000_0000, 5'd4, w);
    send(C_SRL, 32'd0, 32'hF000_0000, 5'd4, w);
    send(C_SLT, 32'hFFFF_FFFF, 32'h1, 5'd0, w);
    send(C_SLTU, 32'hFFFF_FFFF, 32'h1, 5'd0, w);
    send(5'b11010, 32'h5, 32'h6, 5'd0, w);

    // Back-to-back random single-cycle ops at full throughput
    for (int i = 0; i < 24; i++) begin
      send(ops[$urandom_range(0, 15)], $urandom, $urandom, 5'($urandom_range(0, 31)), w);
      chk("throughput", 64'(w), 64'd0);
    end

    // Multiply, with an MFLO offered while it runs
    send(C_MULT, 32'hFFFF_FFFD, 32'd5, 5'd0, w);
`ifdef EXEC_MULDIV_EN
    in_valid = 1'b1; aluctrl = C_MFLO;
    @(negedge clk);
    chk("mflo_during_mul", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
`endif
    send(C_MFLO, 32'd0, 32'd0, 5'd0, w);
`ifdef EXEC_MULDIV_EN
    chk("mul_within_34", 64'(w <= 34), 64'd1);
`endif
    send(C_MFHI, 32'd0, 32'd0, 5'd0, w);
    send(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, w);
    send(C_MFHI, 32'd0, 32'd0, 5'd0, w);
    send(C_MFLO, 32'd0, 32'd0, 5'd0, w);

    // Divide: signed with negative dividend, unsigned by zero
    send(C_DIV, 32'hFFFF_FFF9, 32'd2, 5'd0, w);
    send(C_MFLO, 32'd0, 32'd0, 5'd0, w);
    send(C_MFHI, 32'd0, 32'd0, 5'd0, w);
    send(C_DIVU, 32'd9, 32'd0, 5'd0, w);
    send(C_MFLO, 32'd0, 32'd0, 5'd0, w);
    send(C_MFHI, 32'd0, 32'd0, 5'd0, w);
    send(C_DIVU, 32'd1000, 32'd7, 5'd0, w);
    send(C_MFHI, 32'd0, 32'd0, 5'd0, w);

    // Consumer stall: result holds, input blocked, nothing lost
    repeat (2) @(posedge clk);
    #1 out_ready = 1'b0;
    send(C_ADD, 32'd5, 32'd6, 5'd0, w);
    in_valid = 1'b1; aluctrl = C_OR; d1_in = 32'hA0; d2_in = 32'h0B;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_hold", 64'(d1_out), 64'd11);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(C_OR, 32'hA0, 32'h0B, 5'd0, w);

    // Reset in the middle of a divide
    send(C_DIV, 32'd100, 32'd7, 5'd0, w);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    m_hi = '0; m_lo = '0;
    #1;
    chk("reset_mid_div_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_mid_reset", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    send(C_MFHI, 32'd0, 32'd0, 5'd0, w);
    send(C_MFLO, 32'd0, 32'd0, 5'd0, w);

    for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk); #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
